// File: rtl/display_pkg.sv
// Shared constants and helpers for the five-digit ASCII display path.
package display_pkg;

  localparam int NUM_DIGITS = 5;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [8*NUM_DIGITS-1:0] RESET_MSG = 40'h48454C4C4F; // "HELLO"

  typedef enum logic [1:0] {
    ST_STATIC = 2'b00,
    ST_SCROLL = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

  // Advance a buffer index by one, wrapping at the active message length.
  function automatic logic [4:0] wrap_inc(input logic [4:0] idx, input logic [5:0] len);
    logic [5:0] nxt;
    nxt = {1'b0, idx} + 6'd1;
    if (nxt >= len) wrap_inc = 5'd0;
    else            wrap_inc = nxt[4:0];
  endfunction

  function automatic logic [7:0] reset_char(input int unsigned i);
    if (i < NUM_DIGITS) reset_char = RESET_MSG[8*(NUM_DIGITS-1-i) +: 8];
    else                reset_char = ASCII_SPACE;
  endfunction

endpackage

// File: rtl/marquee_scroll_ctrl_tick_prescaler.sv
// Scroll-rate divider: counts 0..CLK_DIV-1 while enabled, flags the last count.
module tick_prescaler #(
  parameter int CLK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (cnt_r == LAST) cnt_r <= {CW{1'b0}};
      else               cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tc = en && !clr && (cnt_r == LAST);

endmodule

// File: rtl/marquee_scroll_ctrl.sv
// Marquee sequencer: circular message buffer with a 5-character window
// stepped at a programmable rate, feeding five per-digit ASCII decoders.
module marquee_scroll_ctrl #(
  parameter int CLK_DIV = 25000000,
  parameter int MSG_LEN = 16
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic        Pause,
  input  logic        WrEn,
  input  logic [4:0]  WrAddr,
  input  logic [7:0]  WrData,
  input  logic        LenWr,
  input  logic [5:0]  LenIn,
  output logic [39:0] CharOut,
  output logic        Step,
  output logic [4:0]  Pos,
  output logic [1:0]  State
);
  import display_pkg::*;

  localparam logic [5:0] LEN_MAX = 6'(MSG_LEN);

  state_t      state_r, state_s;
  logic        cnt_en_s, cnt_clr_s, tc_s;
  logic [5:0]  len_r, len_s;
  logic [4:0]  pos_r, pos_s, base_s;
  logic [7:0]  msg_r [0:31];
  logic [39:0] char_r, char_s;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (Clock),
    .rst_n (Resetn),
    .en    (cnt_en_s),
    .clr   (cnt_clr_s),
    .tc    (tc_s)
  );

  // Mode sequencing; Run=0 takes priority over Pause.
  always_comb begin
    state_s   = state_r;
    cnt_en_s  = 1'b0;
    cnt_clr_s = 1'b0;
    case (state_r)
      ST_STATIC: begin
        cnt_clr_s = 1'b1;
        if (Run) state_s = ST_SCROLL;
        else     state_s = ST_STATIC;
      end
      ST_SCROLL: begin
        if (!Run) begin
          state_s   = ST_STATIC;
          cnt_clr_s = 1'b1;
        end else if (Pause) begin
          state_s = ST_HOLD;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!Run) begin
          state_s   = ST_STATIC;
          cnt_clr_s = 1'b1;
        end else if (!Pause) begin
          state_s = ST_SCROLL;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s   = ST_STATIC;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Length load and window position; a step is taken against the new length.
  always_comb begin
    if (LenWr) begin
      if (LenIn == 6'd0)         len_s = 6'd1;
      else if (LenIn > LEN_MAX)  len_s = LEN_MAX;
      else                       len_s = LenIn;
    end else begin
      len_s = len_r;
    end

    if ({1'b0, pos_r} >= len_s) base_s = 5'd0;
    else                        base_s = pos_r;

    if (cnt_clr_s)  pos_s = 5'd0;
    else if (tc_s)  pos_s = wrap_inc(base_s, len_s);
    else            pos_s = base_s;
  end

  // Window extraction: digit 4 shows buf[Pos], lower digits follow with wrap.
  always_comb begin
    logic [4:0] idx;
    char_s = {40{1'b0}};
    idx    = pos_r;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      char_s[8*(NUM_DIGITS-1-j) +: 8] = msg_r[idx];
      idx = wrap_inc(idx, len_r);
    end
  end

  // Control state registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= ST_STATIC;
      len_r   <= 6'd5;
      pos_r   <= 5'd0;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      pos_r   <= pos_s;
    end
  end

  // Message buffer; entries at or beyond MSG_LEN are never written or read.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 32; i++) msg_r[i] <= reset_char(i);
    end else if (WrEn && ({1'b0, WrAddr} < LEN_MAX)) begin
      msg_r[WrAddr] <= WrData;
    end
  end

  // Registered display codes.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) char_r <= RESET_MSG;
    else         char_r <= char_s;
  end

  assign CharOut = char_r;
  assign Step    = tc_s;
  assign Pos     = pos_r;
  assign State   = state_r;

endmodule

// File: tb/tb_marquee_scroll_ctrl.sv
// Directed plus randomized bench for marquee_scroll_ctrl against an
// arithmetic reference model of the scrolling window.
module tb_marquee_scroll_ctrl;

  localparam int CLK_DIV = 4;
  localparam int MSG_LEN = 16;
  localparam logic [39:0] S_HELLO = 40'h48454C4C4F;
  localparam logic [39:0] S_ELLOH = 40'h454C4C4F48;
  localparam logic [39:0] S_ABCDE = 40'h4142434445;
  localparam logic [39:0] S_DEFGA = 40'h4445464741;
  localparam logic [39:0] S_ABCAB = 40'h4142434142;
  localparam logic [39:0] S_AAAAA = 40'h4141414141;

  logic        Clock = 1'b0;
  logic        Resetn, Run, Pause, WrEn, LenWr;
  logic [4:0]  WrAddr;
  logic [7:0]  WrData;
  logic [5:0]  LenIn;
  logic [39:0] CharOut;
  logic        Step;
  logic [4:0]  Pos;
  logic [1:0]  State;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model: mode 0 static, 1 scroll, 2 hold
  byte unsigned m_buf [MSG_LEN];
  int m_len, m_pos, m_div, m_mode;
  bit m_step;
  logic [39:0] m_char;

  marquee_scroll_ctrl #(.CLK_DIV(CLK_DIV), .MSG_LEN(MSG_LEN)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Pause(Pause),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .LenWr(LenWr), .LenIn(LenIn),
    .CharOut(CharOut), .Step(Step), .Pos(Pos), .State(State)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [39:0] window();
    logic [39:0] w;
    for (int k = 0; k < 5; k++) w[8*k +: 8] = m_buf[(m_pos + 4 - k) % m_len];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 8'h20;
    m_buf[0] = 8'h48; m_buf[1] = 8'h45; m_buf[2] = 8'h4C; m_buf[3] = 8'h4C; m_buf[4] = 8'h4F;
    m_len = 5; m_pos = 0; m_div = 0; m_mode = 0; m_step = 1'b0;
    m_char = S_HELLO;
  endtask

  task automatic model_clock();
    int  newlen;
    bit  adv, cleared;
    m_char = window();
    newlen = m_len;
    if (LenWr) newlen = (LenIn == 0) ? 1 : ((int'(LenIn) > MSG_LEN) ? MSG_LEN : int'(LenIn));
    adv = 1'b0; cleared = 1'b0;
    if (m_mode == 0) begin
      cleared = 1'b1;
      if (Run) m_mode = 1;
    end else if (!Run) begin
      m_mode = 0; cleared = 1'b1;
    end else if (m_mode == 1) begin
      if (Pause) m_mode = 2;
      else if (m_div == CLK_DIV - 1) begin m_div = 0; adv = 1'b1; end
      else m_div++;
    end else if (!Pause) begin
      m_mode = 1;
    end
    if (cleared) begin
      m_div = 0; m_pos = 0;
    end else begin
      if (LenWr && m_pos >= newlen) m_pos = 0;
      if (adv) m_pos = (m_pos + 1) % newlen;
    end
    if (WrEn && int'(WrAddr) < MSG_LEN) m_buf[WrAddr] = WrData;
    m_len  = newlen;
    m_step = adv;
  endtask

  task automatic check_all();
    chk("charout", CharOut, m_char);
    chk("pos", 40'(Pos), 40'(m_pos));
    chk("state", 40'(State), 40'(m_mode));
  endtask

  // One clock: Step is checked combinationally before the edge, the rest after.
  task automatic tick();
    #1;
    model_clock();
    chk("step", 40'(Step), 40'(m_step));
    @(posedge Clock);
    #1;
    check_all();
  endtask

  initial begin
    int steps, last, n;
    bit want;
    int frozen;

    Resetn = 1'b1; Run = 1'b0; Pause = 1'b0; WrEn = 1'b0; LenWr = 1'b0;
    WrAddr = 5'd0; WrData = 8'd0; LenIn = 6'd0;
    #2 Resetn = 1'b0;
    model_reset();
    #2;
    check_all();
    chk("reset_hello", CharOut, S_HELLO);
    chk("reset_step", 40'(Step), 40'd0);
    #8 Resetn = 1'b1;

    // static display, no steps
    repeat (50) tick();

    // scroll from reset
    Run = 1'b1;
    steps = 0; last = 0; want = 1'b0;
    for (int c = 0; c < 100 && steps < 5; c++) begin
      tick();
      if (want) begin chk("first_window", CharOut, S_ELLOH); want = 1'b0; end
      if (m_step) begin
        steps++;
        if (steps == 1) want = 1'b1;
        else chk("step_period", 40'(c - last), 40'(CLK_DIV));
        last = c;
      end
    end
    chk("five_steps", 40'(steps), 40'd5);
    chk("wrap_pos", 40'(Pos), 40'd0);
    tick();
    chk("wrap_hello", CharOut, S_HELLO);

    // load ABCDEFG with length 7 while static
    Run = 1'b0;
    tick(); tick();
    for (int i = 0; i < 7; i++) begin
      WrEn = 1'b1; WrAddr = 5'(i); WrData = 8'(8'h41 + i);
      if (i == 6) begin LenWr = 1'b1; LenIn = 6'd7; end
      tick();
    end
    WrEn = 1'b0; LenWr = 1'b0;
    tick(); tick();
    chk("abcde", CharOut, S_ABCDE);

    Run = 1'b1;
    steps = 0;
    for (int c = 0; c < 100 && steps < 3; c++) begin tick(); if (m_step) steps++; end
    tick();
    chk("defga", CharOut, S_DEFGA);
    for (int c = 0; c < 100 && steps < 7; c++) begin tick(); if (m_step) steps++; end
    chk("seven_steps", 40'(steps), 40'd7);
    chk("len7_wrap", 40'(Pos), 40'd0);

    // pause mid-count with divider at 2
    n = 0;
    while (n < 20 && !(m_mode == 1 && m_div == 2)) begin tick(); n++; end
    chk("reach_div2", 40'(n < 20), 40'd1);
    frozen = m_pos;
    Pause = 1'b1;
    repeat (10) begin
      tick();
      chk("pause_step", 40'(Step), 40'd0);
      chk("pause_pos", 40'(Pos), 40'(frozen));
    end
    Pause = 1'b0;
    n = 0;
    while (n < 10 && !m_step) begin tick(); n++; end
    chk("resume_latency", 40'(n), 40'd3);

    // length reload while held at position 6
    n = 0;
    while (n < 100 && m_pos != 6) begin tick(); n++; end
    chk("reach_pos6", 40'(Pos), 40'd6);
    Pause = 1'b1;
    tick();
    LenWr = 1'b1; LenIn = 6'd3;
    tick();
    LenWr = 1'b0;
    tick();
    chk("len3_pos", 40'(Pos), 40'd0);
    chk("abcab", CharOut, S_ABCAB);
    LenWr = 1'b1; LenIn = 6'd0;
    tick();
    LenWr = 1'b0;
    tick();
    chk("aaaaa", CharOut, S_AAAAA);
    LenWr = 1'b1; LenIn = 6'd40;
    tick();
    LenWr = 1'b0;
    tick();
    chk("len16_abcde", CharOut, S_ABCDE);
    Pause = 1'b0;
    n = 0;
    while (n < 100 && m_pos != 15) begin tick(); n++; end
    chk("len16_pos15", 40'(Pos), 40'd15);

    // asynchronous reset between edges
    tick();
    #2 Resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("areset_hello", CharOut, S_HELLO);
    chk("areset_step", 40'(Step), 40'd0);
    #3 Resetn = 1'b1;
    Run = 1'b0;
    WrEn = 1'b1; WrAddr = 5'd20; WrData = 8'h5A;
    tick();
    WrEn = 1'b0;
    tick(); tick();
    chk("oob_write", CharOut, S_HELLO);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      Run    = ($urandom_range(0, 9) != 0);
      Pause  = ($urandom_range(0, 5) == 0);
      WrEn   = ($urandom_range(0, 3) == 0);
      WrAddr = 5'($urandom_range(0, 31));
      WrData = 8'($urandom_range(32, 126));
      LenWr  = ($urandom_range(0, 15) == 0);
      LenIn  = 6'($urandom_range(0, 63));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
